mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sits between the requesters (instruction fetcher and load/store buffer) and the byte-serial memory controller.
- Decides which requester owns the memory controller and issues one registered request pulse per transaction.
- Holds the grant until the controller reports completion, then returns data and an ack to the owner.
- Handles pipeline flushes, throttles UART writes when the IO buffer is full, and bounds fetch starvation under heavy LSB traffic.

Parameters:
- LSB_STREAK_MAX, 4: consecutive LSB grants allowed while a fetch is pending; then the fetcher is forced.
- IO_BASE, 32'h0003_0000: addresses >= IO_BASE are IO space.
- STREAK_W, 3: width of the streak counter; must hold LSB_STREAK_MAX.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: reset, asynchronous, active-low.
- rdy_in, input, 1: global ready; low freezes all state.
- flush_in, input, 1: misprediction flush from the ROB.
- io_buffer_full_in, input, 1: UART buffer full.
- if_req_in, input, 1: fetch request, level-held until if_ack_out.
- if_addr_in, input, 32: fetch address (4-byte read).
- if_ack_out, output, 1: one-cycle completion pulse.
- if_data_out, output, 32: fetched instruction, valid with if_ack_out.
- lsb_req_in, input, 1: LSB request, level-held until lsb_ack_out.
- lsb_wr_in, input, 1: 1 = store, 0 = load.
- lsb_size_in, input, 2: extra bytes after the first (00 byte, 01 half, 11 word; 10 is illegal and treated as 11).
- lsb_addr_in, input, 32: LSB address.
- lsb_wdata_in, input, 32: store data.
- lsb_ack_out, output, 1: one-cycle completion pulse.
- lsb_rdata_out, output, 32: raw load data, unextended, valid with lsb_ack_out.
- mc_req_out, output, 1: one-cycle request pulse to the memory controller.
- mc_wr_out, output, 1: write flag.
- mc_size_out, output, 2: byte count code (fetch always 11).
- mc_addr_out, output, 32: request address.
- mc_wdata_out, output, 32: write data.
- mc_busy_in, input, 1: memory controller busy.
- mc_done_in, input, 1: completion pulse.
- mc_rdata_in, input, 32: read data, valid with mc_done_in.

Behaviour:
- Reset (rst_in low, async):
  - state = IDLE, streak = 0.
  - All outputs 0, including if_data_out and lsb_rdata_out.
- rdy_in low: no register changes except async reset.
- States:
  - IDLE
  - ISSUE_IF, WAIT_IF
  - ISSUE_LSB, WAIT_LSB
  - DRAIN
- IDLE, evaluated only when mc_busy_in = 0:
  - LSB eligible = lsb_req_in and not (lsb_wr_in and lsb_addr_in >= IO_BASE and io_buffer_full_in).
  - IF eligible = if_req_in and not flush_in.
  - Both eligible: LSB wins unless streak == LSB_STREAK_MAX, in which case IF wins.
  - On an LSB grant with if_req_in high: streak += 1, saturating.
  - On an IF grant or no pending fetch: streak = 0.
  - Winner's fields are latched; next state is ISSUE_x.
- ISSUE_x:
  - mc_req_out = 1 for exactly one cycle, with the mc_* fields from the latched values.
  - Next state is WAIT_x.
  - Issue latency: request seen in IDLE at cycle N -> mc_req_out at N+1.
- WAIT_IF:
  - On mc_done_in: if_data_out <= mc_rdata_in; if_ack_out pulses the next cycle; go to IDLE.
  - flush_in high in ISSUE_IF or WAIT_IF (done not yet seen): go to DRAIN instead.
  - flush_in in the same cycle as mc_done_in: data is discarded, no ack, go to IDLE.
- DRAIN:
  - Waits for mc_done_in, discards the data, returns to IDLE.
  - if_ack_out is never asserted from DRAIN.
- WAIT_LSB:
  - Never cancelled by flush; the LSB owns flush semantics.
  - On mc_done_in: lsb_rdata_out <= mc_rdata_in for loads, 0 for stores; lsb_ack_out pulses the next cycle; go to IDLE.
- Back-to-back: at least one IDLE cycle between transactions. Requesters must drop req in the cycle after ack.
- mc_done_in outside WAIT_x or DRAIN is ignored.
- Ack and request outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - state encoding
  - size codes (SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b11)
  - IO_BASE
- Sub-module mem_arb_pick (combinational priority/streak decision) is natural: it is about 30 lines and can be tested on its own.

Test Plan:
- IF-only: if_req_in, addr 0x100, done after 5 cycles with rdata 0x00000093 -> mc_req_out at N+1 with size 11; if_ack_out one cycle after done with if_data_out = 0x00000093.
- Contention: both requesters held continuously, LSB_STREAK_MAX = 4 -> grant order LSB, LSB, LSB, LSB, IF, LSB, and so on.
- Flush mid-fetch: flush_in in WAIT_IF -> DRAIN; done consumed; no if_ack_out; next grant goes to a pending LSB request.
- IO throttle: LSB store to 0x30000 with io_buffer_full_in = 1 and if_req_in = 1 -> IF granted, store held; full drops -> store issued with mc_wr_out = 1.
- Async reset: rst_in low during WAIT_LSB -> all outputs 0 immediately; after release, state = IDLE and no spurious ack.
- rdy_in low for 3 cycles in ISSUE_IF -> mc_req_out stays a single pulse after rdy_in returns; state is preserved.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter.
// Holds the controller state encoding, the byte-count size codes, the IO base
// address default, and a helper that folds the illegal size code onto word.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_IF,
    ST_WAIT_IF,
    ST_ISSUE_LSB,
    ST_WAIT_LSB,
    ST_DRAIN
  } arb_state_t;

  // Size codes give the number of extra bytes after the first one.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // 2'b10 has no meaning to the controller; treat it as a full word.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b10) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the memory controller.
// master : arbiter view (takes requester requests and controller status,
//          drives acks/data back to requesters and the request to the controller)
// slave  : environment view (requesters plus memory controller)
// Signals:
//   if_*  : instruction fetcher request/ack/data
//   lsb_* : load/store buffer request/ack/data
//   mc_*  : memory controller request fields and completion status
interface mem_arbiter_if;

  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_ack_out;
  logic [31:0] if_data_out;

  logic        lsb_req_in;
  logic        lsb_wr_in;
  logic [1:0]  lsb_size_in;
  logic [31:0] lsb_addr_in;
  logic [31:0] lsb_wdata_in;
  logic        lsb_ack_out;
  logic [31:0] lsb_rdata_out;

  logic        mc_req_out;
  logic        mc_wr_out;
  logic [1:0]  mc_size_out;
  logic [31:0] mc_addr_out;
  logic [31:0] mc_wdata_out;
  logic        mc_busy_in;
  logic        mc_done_in;
  logic [31:0] mc_rdata_in;

  modport master (
    input  if_req_in, if_addr_in,
    output if_ack_out, if_data_out,
    input  lsb_req_in, lsb_wr_in, lsb_size_in, lsb_addr_in, lsb_wdata_in,
    output lsb_ack_out, lsb_rdata_out,
    output mc_req_out, mc_wr_out, mc_size_out, mc_addr_out, mc_wdata_out,
    input  mc_busy_in, mc_done_in, mc_rdata_in
  );

  modport slave (
    output if_req_in, if_addr_in,
    input  if_ack_out, if_data_out,
    output lsb_req_in, lsb_wr_in, lsb_size_in, lsb_addr_in, lsb_wdata_in,
    input  lsb_ack_out, lsb_rdata_out,
    input  mc_req_out, mc_wr_out, mc_size_out, mc_addr_out, mc_wdata_out,
    output mc_busy_in, mc_done_in, mc_rdata_in
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational grant decision for the memory arbiter.
// Ports:
//   if_req, flush             : fetch request and pipeline flush
//   lsb_req, lsb_wr, lsb_addr : LSB request, direction and address
//   io_full                   : UART buffer full (blocks IO stores)
//   streak                    : consecutive LSB grants while a fetch waited
//   grant_if, grant_lsb       : one-hot (or none) winner
//   streak_next               : streak value to store if this decision is taken
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned  LSB_STREAK_MAX = 4,
  parameter int unsigned  STREAK_W       = 3,
  parameter logic [31:0]  IO_BASE        = IO_BASE_DEFAULT
) (
  input  logic                if_req,
  input  logic                flush,
  input  logic                lsb_req,
  input  logic                lsb_wr,
  input  logic [31:0]         lsb_addr,
  input  logic                io_full,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_if,
  output logic                grant_lsb,
  output logic [STREAK_W-1:0] streak_next
);

  localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(LSB_STREAK_MAX);

  logic lsb_ok;
  logic if_ok;
  logic force_if;

  always_comb begin
    // A store into IO space must wait while the UART cannot take it.
    lsb_ok    = lsb_req && !(lsb_wr && (lsb_addr >= IO_BASE) && io_full);
    if_ok     = if_req && !flush;
    force_if  = (streak == STREAK_CAP);
    grant_if  = if_ok && (!lsb_ok || force_if);
    grant_lsb = lsb_ok && !grant_if;

    // The streak can only sit at the cap with an LSB grant if the fetch was
    // ineligible (flush), so saturate there rather than wrap.
    if (grant_lsb && if_req)
      streak_next = force_if ? streak : streak + STREAK_W'(1);
    else if (grant_if || !if_req)
      streak_next = '0;
    else
      streak_next = streak;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter between the instruction fetcher / load-store buffer and the
// byte-serial memory controller. One registered request pulse per transaction,
// grant held until the controller completes, then data plus a one-cycle ack.
// Ports:
//   clk_in            : system clock
//   rst_in            : asynchronous active-low reset
//   rdy_in            : global ready, low freezes all state
//   flush_in          : misprediction flush (cancels an outstanding fetch)
//   io_buffer_full_in : UART buffer full, holds stores to IO space
//   bus               : requester and memory-controller signals (master view)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned  LSB_STREAK_MAX = 4,
  parameter int unsigned  STREAK_W       = 3,
  parameter logic [31:0]  IO_BASE        = IO_BASE_DEFAULT
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            flush_in,
  input  logic            io_buffer_full_in,
  mem_arbiter_if.master   bus
);

  arb_state_t          state_reg;
  logic [STREAK_W-1:0] streak_reg;
  logic [STREAK_W-1:0] streak_next;
  logic                grant_if;
  logic                grant_lsb;

  logic                mc_req_reg;
  logic                mc_wr_reg;
  logic [1:0]          mc_size_reg;
  logic [31:0]         mc_addr_reg;
  logic [31:0]         mc_wdata_reg;
  logic                if_ack_reg;
  logic [31:0]         if_data_reg;
  logic                lsb_ack_reg;
  logic [31:0]         lsb_rdata_reg;

  mem_arb_pick #(
    .LSB_STREAK_MAX (LSB_STREAK_MAX),
    .STREAK_W       (STREAK_W),
    .IO_BASE        (IO_BASE)
  ) u_pick (
    .if_req      (bus.if_req_in),
    .flush       (flush_in),
    .lsb_req     (bus.lsb_req_in),
    .lsb_wr      (bus.lsb_wr_in),
    .lsb_addr    (bus.lsb_addr_in),
    .io_full     (io_buffer_full_in),
    .streak      (streak_reg),
    .grant_if    (grant_if),
    .grant_lsb   (grant_lsb),
    .streak_next (streak_next)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg     <= ST_IDLE;
      streak_reg    <= '0;
      mc_req_reg    <= 1'b0;
      mc_wr_reg     <= 1'b0;
      mc_size_reg   <= 2'b00;
      mc_addr_reg   <= '0;
      mc_wdata_reg  <= '0;
      if_ack_reg    <= 1'b0;
      if_data_reg   <= '0;
      lsb_ack_reg   <= 1'b0;
      lsb_rdata_reg <= '0;
    end else if (rdy_in) begin
      mc_req_reg  <= 1'b0;
      if_ack_reg  <= 1'b0;
      lsb_ack_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // The ack cycle is a forced gap: the owner still holds req here.
          if (!bus.mc_busy_in && !if_ack_reg && !lsb_ack_reg) begin
            streak_reg <= streak_next;
            if (grant_lsb) begin
              mc_req_reg   <= 1'b1;
              mc_wr_reg    <= bus.lsb_wr_in;
              mc_size_reg  <= norm_size(bus.lsb_size_in);
              mc_addr_reg  <= bus.lsb_addr_in;
              mc_wdata_reg <= bus.lsb_wdata_in;
              state_reg    <= ST_ISSUE_LSB;
            end else if (grant_if) begin
              mc_req_reg   <= 1'b1;
              mc_wr_reg    <= 1'b0;
              mc_size_reg  <= SZ_WORD;
              mc_addr_reg  <= bus.if_addr_in;
              mc_wdata_reg <= '0;
              state_reg    <= ST_ISSUE_IF;
            end
          end
        end
        ST_ISSUE_IF:  state_reg <= flush_in ? ST_DRAIN : ST_WAIT_IF;
        ST_WAIT_IF: begin
          if (bus.mc_done_in) begin
            // A flush coinciding with completion drops the stale instruction.
            if (!flush_in) begin
              if_data_reg <= bus.mc_rdata_in;
              if_ack_reg  <= 1'b1;
            end
            state_reg <= ST_IDLE;
          end else if (flush_in) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_ISSUE_LSB: state_reg <= ST_WAIT_LSB;
        ST_WAIT_LSB: begin
          if (bus.mc_done_in) begin
            lsb_rdata_reg <= mc_wr_reg ? 32'h0 : bus.mc_rdata_in;
            lsb_ack_reg   <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (bus.mc_done_in) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.mc_req_out    = mc_req_reg;
  assign bus.mc_wr_out     = mc_wr_reg;
  assign bus.mc_size_out   = mc_size_reg;
  assign bus.mc_addr_out   = mc_addr_reg;
  assign bus.mc_wdata_out  = mc_wdata_reg;
  assign bus.if_ack_out    = if_ack_reg;
  assign bus.if_data_out   = if_data_reg;
  assign bus.lsb_ack_out   = lsb_ack_reg;
  assign bus.lsb_rdata_out = lsb_rdata_reg;

endmodule
